// File: rtl/system_id_regs_if.sv
// Avalon-MM slave bus bundle for the system-ID peripheral, plus its interrupt line.
interface system_id_regs_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              readdatavalid;
    logic              irq;

    modport master (output address, read, write, writedata,
                    input  readdata, readdatavalid, irq);
    modport slave  (input  address, read, write, writedata,
                    output readdata, readdatavalid, irq);
endinterface

// File: rtl/system_id_regs.sv
// System identification slave: ID/timestamp constants, uptime counter with coherent
// 64-bit snapshot, control/status with sticky overflow interrupt, scratch registers.
module system_id_regs #(
    parameter logic [31:0] ID_VALUE     = 32'hA5A5_0001,
    parameter logic [31:0] TIMESTAMP    = 32'd0,
    parameter int          UPTIME_WIDTH = 64,
    parameter int          NUM_SCRATCH  = 2,
    parameter int          ADDR_W       = 4,
    parameter int          READ_LATENCY = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    system_id_regs_if.slave bus
);
    localparam int HI_W  = UPTIME_WIDTH - 32;
    localparam int SCR_N = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;

    logic [31:0]             addr;
    logic                    wr_ctrl, wr_stat, clear, wrap;
    logic [UPTIME_WIDTH-1:0] cnt_q, cnt_d;
    logic [HI_W-1:0]         hi_q, hi_d;
    logic                    freeze_q, freeze_d;
    logic                    irq_en_q, irq_en_d;
    logic                    ovf_q, ovf_d;
    logic                    irq_q, irq_d;
    logic [SCR_N-1:0][31:0]  scratch_q, scratch_d;
    logic [31:0]             rd_val;

    logic [READ_LATENCY:1]       vld_pipe_q;
    logic [READ_LATENCY:1][31:0] dat_pipe_q;

    assign addr    = 32'(bus.address);
    assign wr_ctrl = bus.write && (addr == 32'd4);
    assign wr_stat = bus.write && (addr == 32'd5);
    assign clear   = wr_ctrl && bus.writedata[1];
    assign wrap    = !clear && !freeze_q && (&cnt_q);

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        freeze_d  = freeze_q;
        irq_en_d  = irq_en_q;
        ovf_d     = ovf_q;
        scratch_d = scratch_q;

        if (clear)          cnt_d = '0;
        else if (!freeze_q) cnt_d = cnt_q + 1'b1;

        // Only a LO read snapshots the upper bits, so LO-then-HI is coherent.
        if (bus.read && (addr == 32'd2)) hi_d = cnt_q[UPTIME_WIDTH-1:32];

        if (wr_ctrl) begin
            freeze_d = bus.writedata[0];
            irq_en_d = bus.writedata[2];
        end

        // Set beats the W1C when both land on the same edge.
        if (wrap)                            ovf_d = 1'b1;
        else if (wr_stat && bus.writedata[0]) ovf_d = 1'b0;

        for (int n = 0; n < NUM_SCRATCH; n++)
            if (bus.write && (addr == 32'(6 + n))) scratch_d[n] = bus.writedata;
    end

    assign irq_d = ovf_q && irq_en_q;

    always_comb begin
        rd_val = '0;
        case (addr)
            32'd0:   rd_val = ID_VALUE;
            32'd1:   rd_val = TIMESTAMP;
            32'd2:   rd_val = cnt_q[31:0];
            32'd3:   rd_val = 32'(hi_q);
            32'd4:   rd_val = {29'd0, irq_en_q, 1'b0, freeze_q};
            32'd5:   rd_val = {31'd0, ovf_q};
            default: begin
                for (int n = 0; n < NUM_SCRATCH; n++)
                    if (addr == 32'(6 + n)) rd_val = scratch_q[n];
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            freeze_q  <= 1'b0;
            irq_en_q  <= 1'b0;
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
            scratch_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            freeze_q  <= freeze_d;
            irq_en_q  <= irq_en_d;
            ovf_q     <= ovf_d;
            irq_q     <= irq_d;
            scratch_q <= scratch_d;
        end
    end

    // Read pipeline; each stage only loads on valid so readdata holds between pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe_q <= '0;
            dat_pipe_q <= '0;
        end else begin
            vld_pipe_q[1] <= bus.read;
            if (bus.read) dat_pipe_q[1] <= rd_val;
            for (int i = 2; i <= READ_LATENCY; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                if (vld_pipe_q[i-1]) dat_pipe_q[i] <= dat_pipe_q[i-1];
            end
        end
    end

    assign bus.readdata      = dat_pipe_q[READ_LATENCY];
    assign bus.readdatavalid = vld_pipe_q[READ_LATENCY];
    assign bus.irq           = irq_q;
endmodule

// File: doc/system_id_regs.md
# system_id_regs

Parametrised system-identification peripheral for the Qsys/Avalon-MM fabric, succeeding the single-word constant ID slave. Adds a build timestamp register, a free-running uptime counter with an atomic 64-bit snapshot, control/status with a sticky overflow flag and interrupt, and software scratch registers. Read data is registered with a fixed, parametrised read latency. Sits on the system interconnect as a low-bandwidth control slave read by the boot/diagnostic software.

## Interface
- ID_VALUE, 32'hA5A5_0001, system ID constant returned at word 0
- TIMESTAMP, 32'd0, build timestamp constant returned at word 1
- UPTIME_WIDTH, 64, uptime counter width; legal 33..64
- NUM_SCRATCH, 2, number of 32-bit scratch registers; legal 0..(2^ADDR_W − 6)
- ADDR_W, 4, word-address width
- READ_LATENCY, 1, cycles from read to readdatavalid; legal 1 or 2

- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  ADDR_W  word address
- read  in  1  read strobe, one cycle per access
- write  in  1  write strobe, one cycle per access
- writedata  in  32  write data
- readdata  out  32  registered read data
- readdatavalid  out  1  readdata qualifier, one-cycle pulse
- irq  out  1  level interrupt, = OVF & IRQ_EN

## Operation
- Register map (word addresses):
  - 0 ID: RO, ID_VALUE
  - 1 TIMESTAMP: RO, TIMESTAMP
  - 2 UPTIME_LO: RO, counter[31:0]; the same read copies counter[UPTIME_WIDTH-1:32] into HI_SHADOW
  - 3 UPTIME_HI: RO, HI_SHADOW zero-extended to 32 bits; does not resample
  - 4 CONTROL: RW; bit0 FREEZE, bit1 CLEAR (write-1 pulse, always reads 0), bit2 IRQ_EN; other bits read 0
  - 5 STATUS: bit0 OVF sticky, write-1-to-clear; other bits read 0
  - 6..6+NUM_SCRATCH−1 SCRATCH[n]: RW, full 32 bits
  - all other addresses: read 0, writes ignored
- Uptime counter: +1 every cycle unless FREEZE=1. Priority per cycle: CLEAR (next value 0) > FREEZE (hold) > increment.
- Wrap from all-ones to 0 sets OVF. If a W1C of OVF coincides with a wrap, set wins and OVF stays 1.
- CLEAR does not touch OVF or HI_SHADOW.
- Writes to RO registers are ignored.
- read and write asserted in the same cycle: both are accepted. The read returns the pre-write value; the write takes effect at the same edge.
- HI_SHADOW is updated only by a read of UPTIME_LO.

## Timing
- Reset values: readdata 0, readdatavalid 0, irq 0, counter 0, HI_SHADOW 0, CONTROL 0, OVF 0, scratch 0.
- Reset asserted mid-read cancels any pending readdatavalid. No stale pulse after reset release.
- Read sampling: the register value is taken at the edge that accepts read; for UPTIME_LO this is the counter value before that edge's increment.
- READ_LATENCY=1: readdata/readdatavalid valid in the cycle after read.
- READ_LATENCY=2: one additional pipeline stage holds data and valid, so they appear two cycles after read.
- Back-to-back reads every cycle are supported at full rate, each returning in order.
- readdata holds its last value when readdatavalid=0.
- Writes take effect at the accepting edge; a read in the following cycle sees the new value.
- irq is registered: it rises one cycle after OVF sets with IRQ_EN=1, and falls one cycle after OVF is cleared or IRQ_EN is written 0.

## Test plan
- Reset, read addresses 0,1,7,15 (NUM_SCRATCH=2) -> 32'hA5A5_0001, TIMESTAMP, 0 (scratch), 0; readdatavalid exactly READ_LATENCY cycles after each read; back-to-back reads stay in order.
- Freeze counter, CLEAR, then release FREEZE; after 10 cycles read UPTIME_LO -> value 10 ± fixed pipeline offset. Verify the bench's exact expectation against a cycle model.
- UPTIME_WIDTH=40: force counter to 40'h00_FFFF_FFFF via CLEAR plus elapsed cycles (or a bench-only preload), read LO then HI -> LO and HI are coherent across the 32-bit carry. A HI reread with no LO read returns the unchanged shadow.
- UPTIME_WIDTH=33: run to wrap -> OVF=1. With IRQ_EN=1, irq rises the next cycle. Write STATUS=1 in the same cycle as a second wrap -> OVF stays 1. Clear it later -> irq falls one cycle after.
- Write SCRATCH0=32'hDEAD_BEEF, SCRATCH1=32'h1234_5678, and ID=0 -> reads return DEAD_BEEF, 1234_5678, and ID unchanged. Simultaneous read+write of SCRATCH0 with 32'h0 returns DEAD_BEEF; the next read returns 0.
- Assert reset_n low in the cycle after a read -> no readdatavalid pulse. All registers read back at reset values after release.
